prewish_mentor_fifo: RTL and testbench

//  Parametrised successor mentor. Captures words strobed in on the student side (STB_I/DAT_I).

---
 rtl/prewish_mentor_fifo_if.sv | 13 +
 rtl/prewish_mentor_fifo.sv | 183 ++++++++++++++++++
 tb/tb_prewish_mentor_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prewish_mentor_fifo_if.sv
// Strobe/data bus used on both sides of the mentor FIFO.
//   stb : strobe (student side: async capture request; blinky side: replay pulse)
//   dat : data word, DATA_W bits
//   master drives stb/dat, slave observes them.
interface prewish_mentor_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic              stb;
  logic [DATA_W-1:0] dat;

  modport master (output stb, output dat);
  modport slave  (input  stb, input  dat);
endinterface

// File: rtl/prewish_mentor_fifo.sv
// Mentor FIFO: captures student strobes through a synchroniser, buffers the
// words in a DEPTH-entry circular FIFO and replays each one to the blinky as a
// STB_LEN-cycle pulse followed by at least GAP_LEN low cycles.
//   CLK_I    : clock, posedge
//   RST_I    : async active-low reset
//   student  : slave bus, async strobe/data from the student
//   blinky   : master bus, replay strobe/data to the blinky
//   COUNT_O  : words held in the FIFO
//   FULL_O   : COUNT_O == DEPTH
//   OVF_O    : sticky, a word was dropped because the FIFO was full
//   o_alive  : toggles per accepted word, resets to 1
module prewish_mentor_fifo #(
  parameter  int unsigned DATA_W      = 8,
  parameter  int unsigned DEPTH       = 4,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned STB_LEN     = 1,
  parameter  int unsigned GAP_LEN     = 1,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  prewish_mentor_fifo_if.slave  student,
  prewish_mentor_fifo_if.master blinky,
  output logic [CNT_W-1:0]      COUNT_O,
  output logic                  FULL_O,
  output logic                  OVF_O,
  output logic                  o_alive
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned TMR_MAX = (STB_LEN > GAP_LEN) ? STB_LEN : GAP_LEN;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]             r_stb_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_dat_sync;
  logic                               r_stb_d;
  logic                               w_stb_s;
  logic [DATA_W-1:0]                  w_dat_s;
  logic                               w_push_req;

  logic [DEPTH-1:0][DATA_W-1:0]       r_mem;
  logic [PTR_W-1:0]                   r_wr_ptr;
  logic [PTR_W-1:0]                   r_rd_ptr;
  logic [CNT_W-1:0]                   r_count;
  logic [CNT_W-1:0]                   w_count_nxt;
  logic                               r_full;
  logic                               w_full;
  logic                               w_push;
  logic                               w_drop;
  logic                               r_ovf;
  logic                               r_alive;

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [TMR_W-1:0]                   r_tmr;
  logic [TMR_W-1:0]                   w_tmr_nxt;
  logic                               w_pop;
  logic                               r_stb;
  logic [DATA_W-1:0]                  r_dat;

  assign w_stb_s    = r_stb_sync[SYNC_STAGES-1];
  assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
  assign w_push_req = w_stb_s & ~r_stb_d;

  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_push = w_push_req & (~w_full | w_pop);
  assign w_drop = w_push_req & w_full & ~w_pop;

  // Synchronisers; reset to 0 so STB_I held high over reset release is one rise.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_stb_sync <= '0;
      r_dat_sync <= '0;
      r_stb_d    <= 1'b0;
    end else begin
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], student.stb};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], student.dat};
      r_stb_d    <= w_stb_s;
    end
  end

  // Occupancy next value.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage, pointers and status flags.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_ovf    <= 1'b0;
      r_alive  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dat_s;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_ovf   <= r_ovf | w_drop;
      r_alive <= r_alive ^ w_push;
    end
  end

  // Output FSM next-state: pop in IDLE, hold pulse, then enforce the gap.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_tmr_nxt   = TMR_W'(STB_LEN - 1);
          w_state_nxt = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (r_tmr == '0) begin
          w_tmr_nxt   = TMR_W'(GAP_LEN - 1);
          w_state_nxt = ST_GAP;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_nxt = r_tmr - TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // FSM state and registered blinky outputs; DAT_O only changes on a pop.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_stb   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_stb   <= (w_state_nxt == ST_STROBE);
      if (w_pop) begin
        r_dat <= r_mem[r_rd_ptr];
      end
    end
  end

  assign blinky.stb = r_stb;
  assign blinky.dat = r_dat;
  assign COUNT_O    = r_count;
  assign FULL_O     = r_full;
  assign OVF_O      = r_ovf;
  assign o_alive    = r_alive;

endmodule

// File: tb/tb_prewish_mentor_fifo.sv
// Scoreboard bench for prewish_mentor_fifo with a transaction-level model:
// student rises become push requests SYNC cycles later, a word leaves the
// queue whenever the replay engine is free, and each pop opens a window of
// STB_LEN high cycles plus GAP_LEN low cycles before the next pop.
module tb_prewish_mentor_fifo;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned S_LEN  = 6;
  localparam int unsigned G_LEN  = 3;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n = 1'b0;
  logic              stb_i = 1'b0;
  logic [DATA_W-1:0] dat_i = '0;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              ovf_o;
  logic              alive_o;

  prewish_mentor_fifo_if #(.DATA_W(DATA_W)) stu_if ();
  prewish_mentor_fifo_if #(.DATA_W(DATA_W)) blk_if ();

  assign stu_if.stb = stb_i;
  assign stu_if.dat = dat_i;

  prewish_mentor_fifo #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .STB_LEN     (S_LEN),
    .GAP_LEN     (G_LEN)
  ) dut (
    .CLK_I   (clk),
    .RST_I   (rst_n),
    .student (stu_if),
    .blinky  (blk_if),
    .COUNT_O (count_o),
    .FULL_O  (full_o),
    .OVF_O   (ovf_o),
    .o_alive (alive_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int max_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] sb[$];
  logic              hs[SYNC+1];
  logic [DATA_W-1:0] hd[SYNC+1];
  int                m_wait     = 0;
  int                m_stb_left = 0;
  logic              m_ovf      = 1'b0;
  logic              m_alive    = 1'b1;

  task automatic model_reset();
    mq.delete();
    sb.delete();
    for (int k = 0; k <= SYNC; k++) begin
      hs[k] = 1'b0;
      hd[k] = '0;
    end
    m_wait     = 0;
    m_stb_left = 0;
    m_ovf      = 1'b0;
    m_alive    = 1'b1;
  endtask

  task automatic model_step();
    logic              req;
    logic [DATA_W-1:0] d;
    int                pre;
    logic              pop;
    req = hs[SYNC-1] && !hs[SYNC];
    d   = hd[SYNC-1];
    pre = mq.size();
    pop = (pre != 0) && (m_wait == 0);
    if (pop) begin
      sb.push_back(mq.pop_front());
      m_wait     = S_LEN + G_LEN;
      m_stb_left = S_LEN;
    end else begin
      if (m_wait > 0) m_wait--;
      if (m_stb_left > 0) m_stb_left--;
    end
    if (req) begin
      if (pre < DEPTH || pop) begin
        mq.push_back(d);
        m_alive = ~m_alive;
      end else begin
        m_ovf = 1'b1;
      end
    end
    for (int k = SYNC; k > 0; k--) begin
      hs[k] = hs[k-1];
      hd[k] = hd[k-1];
    end
    hs[0] = stb_i;
    hd[0] = dat_i;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Monitor: per-cycle status plus pulse-level data/length/gap checks.
  logic              mon_prev = 1'b0;
  logic              mon_seen = 1'b0;
  int                mon_hi   = 0;
  int                mon_gap  = 0;
  logic [DATA_W-1:0] mon_cur  = '0;

  initial begin
    forever begin
      @(negedge clk);
      check("stb_o",   blk_if.stb, (m_stb_left > 0));
      check("count_o", count_o, mq.size());
      check("full_o",  full_o, (mq.size() == DEPTH));
      check("ovf_o",   ovf_o, m_ovf);
      check("alive_o", alive_o, m_alive);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      if (!rst_n) begin
        mon_prev = 1'b0;
        mon_seen = 1'b0;
        mon_hi   = 0;
        mon_gap  = 0;
        mon_cur  = '0;
      end else begin
        if (blk_if.stb && !mon_prev) begin
          n_pulses++;
          check("sb_has_word", (sb.size() != 0), 1'b1);
          if (sb.size() != 0) mon_cur = sb.pop_front();
          check("dat_head", blk_if.dat, mon_cur);
          if (mon_seen) check("gap_len_ok", (mon_gap >= G_LEN), 1'b1);
          mon_hi = 1;
        end else if (blk_if.stb) begin
          mon_hi++;
          check("dat_hold_hi", blk_if.dat, mon_cur);
        end else if (mon_prev) begin
          check("pulse_len", mon_hi, S_LEN);
          check("dat_hold_lo", blk_if.dat, mon_cur);
          mon_seen = 1'b1;
          mon_gap  = 1;
        end else begin
          mon_gap++;
          check("dat_hold_lo", blk_if.dat, mon_cur);
        end
        mon_prev = blk_if.stb;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [DATA_W-1:0] d, input int hi, input int lo);
    dat_i = d;
    stb_i = 1'b0;
    repeat (3) @(negedge clk);
    stb_i = 1'b1;
    repeat (hi) @(negedge clk);
    stb_i = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic drain();
    int i;
    i = 0;
    stb_i = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    while (i < 400 && !(mq.size() == 0 && m_stb_left == 0 && m_wait == 0)) begin
      @(negedge clk);
      i++;
    end
    check("drain_in_time", (i < 400), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p0;
    int w;
    logic found;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_stb", blk_if.stb, 1'b0);
    check("rst_dat", blk_if.dat, 8'h00);
    check("rst_alive", alive_o, 1'b1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single word latency: high only after edge SYNC+2
    p0 = n_pulses;
    dat_i = 8'hB4;
    repeat (3) @(negedge clk);
    stb_i = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_early", blk_if.stb, 1'b0);
    @(negedge clk);
    check("t1_stb", blk_if.stb, 1'b1);
    check("t1_dat", blk_if.dat, 8'hB4);
    check("t1_count", count_o, 0);
    repeat (6) @(negedge clk);
    drain();
    check("t1_pulses", n_pulses - p0, 1);
    check("t1_alive", alive_o, 1'b0);
    check("t1_ovf", ovf_o, 1'b0);
    check("t1_dat_kept", blk_if.dat, 8'hB4);

    // Spaced strobes never build up
    do_reset();
    p0 = n_pulses;
    max_cnt = 0;
    for (int k = 1; k <= 5; k++) strobe(DATA_W'(k), 3, 4);
    drain();
    check("t2_pulses", n_pulses - p0, 5);
    check("t2_max_cnt", max_cnt, 1);

    // Overflow: eight quick strobes, the last one is dropped
    do_reset();
    p0 = n_pulses;
    for (int k = 0; k < 8; k++) strobe(DATA_W'(8'h10 + k), 1, 0);
    repeat (2) @(negedge clk);
    check("t3_full", full_o, 1'b1);
    check("t3_ovf", ovf_o, 1'b1);
    drain();
    check("t3_pulses", n_pulses - p0, 7);
    check("t3_ovf_sticky", ovf_o, 1'b1);
    check("t3_alive", alive_o, 1'b0);

    // Push into a full FIFO on the same edge as a pop
    do_reset();
    for (int k = 0; k < 7; k++) strobe(DATA_W'(8'h20 + k), 1, 0);
    dat_i = 8'hA5;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mq.size() == DEPTH && m_wait >= 2) found = 1'b1;
    end
    check("t4_full_found", found, 1'b1);
    w = m_wait;
    for (int i = 0; i < w - 2; i++) @(negedge clk);
    stb_i = 1'b1;
    @(negedge clk);
    stb_i = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_count", count_o, DEPTH);
    check("t4_ovf", ovf_o, 1'b0);
    drain();
    check("t4_dat_last", blk_if.dat, 8'hA5);

    // Reset in the middle of a pulse with two words buffered
    do_reset();
    for (int k = 0; k < 4; k++) strobe(DATA_W'(8'h30 + k), 1, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mq.size() == 2 && m_stb_left > 0) found = 1'b1;
    end
    check("t5_found", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_stb_now", blk_if.stb, 1'b0);
    check("t5_count_now", count_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    p0 = n_pulses;
    repeat (30) @(negedge clk);
    check("t5_quiet", n_pulses - p0, 0);

    // STB_I held high across reset release
    @(negedge clk);
    dat_i = 8'h5A;
    stb_i = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    p0 = n_pulses;
    repeat (50) @(negedge clk);
    check("t6_pulses", n_pulses - p0, 1);
    check("t6_dat", blk_if.dat, 8'h5A);
    drain();

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 40; k++) begin
      strobe(DATA_W'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(0, 6)));
    end
    drain();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
